// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU front end: pc_sel encoding (also used by
// the decoder), the fetch FSM state type and the default reset/halt addresses.
package mips_cpu_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_REG    = 2'b11;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/mips_cpu_next_pc.sv
// Combinational control-transfer evaluation: decides whether the instruction
// in EXEC transfers control and where to. Only instr[25:0] matters here.
module mips_cpu_next_pc
    import mips_cpu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [25:0] i_instr,
    input  logic [1:0]  i_pc_sel,
    input  logic        i_is_branch,
    input  logic        i_is_true,
    input  logic [31:0] i_reg_target,
    output logic [31:0] o_pc_plus4,
    output logic        o_taken,
    output logic [31:0] o_target
);

    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;

    // Candidate targets; all arithmetic wraps modulo 2^32
    always_comb begin
        o_pc_plus4   = i_pc + 32'd4;
        w_br_target  = o_pc_plus4 + {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
        w_jmp_target = {o_pc_plus4[31:28], i_instr[25:0], 2'b00};
    end

    // Select target and qualify the transfer; is_branch=0 overrides pc_sel
    always_comb begin
        o_taken  = 1'b0;
        o_target = o_pc_plus4;
        case (i_pc_sel)
            PC_SEL_BRANCH: begin
                o_taken  = i_is_true;
                o_target = w_br_target;
            end
            PC_SEL_JUMP: begin
                o_taken  = 1'b1;
                o_target = w_jmp_target;
            end
            PC_SEL_REG: begin
                o_taken  = 1'b1;
                o_target = i_reg_target;
            end
            default: begin
                o_taken  = 1'b0;
                o_target = o_pc_plus4;
            end
        endcase
        if (!i_is_branch) o_taken = 1'b0;
    end

endmodule

// File: rtl/mips_cpu_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory through an
// Avalon-style read with waitrequest, presents one instruction per EXEC cycle
// and applies taken transfers after one branch delay slot. Jumping to
// HALT_ADDR or to a misaligned address stops the CPU until reset.
module mips_cpu_fetch
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instr_readdata_out,
    output logic        instr_valid,
    input  logic [1:0]  pc_sel,
    input  logic        is_branch,
    input  logic        is_true,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr,
    output logic        active,
    output logic        fault
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_delay_pending;
    logic [31:0] r_pending_target;
    logic        r_fault;

    logic [31:0] w_pc_plus4;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_new_pc;
    logic        w_halt_hit;
    logic        w_misaligned;

    mips_cpu_next_pc u_next_pc (
        .i_pc         (r_pc),
        .i_instr      (r_instr[25:0]),
        .i_pc_sel     (pc_sel),
        .i_is_branch  (is_branch),
        .i_is_true    (is_true),
        .i_reg_target (reg_target),
        .o_pc_plus4   (w_pc_plus4),
        .o_taken      (w_taken),
        .o_target     (w_target)
    );

    // PC loaded at the end of EXEC: a delay slot consumes the pending target,
    // otherwise execution continues sequentially (transfers land one slot later)
    always_comb begin
        w_new_pc     = r_delay_pending ? r_pending_target : w_pc_plus4;
        w_halt_hit   = (w_new_pc == HALT_ADDR);
        w_misaligned = !w_halt_hit && (w_new_pc[1:0] != 2'b00);
    end

    // Next-state logic for the fetch FSM
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: w_next_state = ST_WAIT;
            ST_WAIT:  if (!instr_waitrequest) w_next_state = ST_EXEC;
            ST_EXEC:  w_next_state = (w_halt_hit || w_misaligned) ? ST_HALT : ST_FETCH;
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_HALT;
        endcase
    end

    // State register; clk_enable=0 freezes the FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          r_state <= ST_FETCH;
        else if (clk_enable) r_state <= w_next_state;
    end

    // Datapath registers: instruction capture, PC update, delay slot tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc             <= RESET_VECTOR;
            r_instr          <= 32'd0;
            r_delay_pending  <= 1'b0;
            r_pending_target <= 32'd0;
            r_fault          <= 1'b0;
        end else if (clk_enable) begin
            if (r_state == ST_WAIT && !instr_waitrequest) r_instr <= instr_readdata;
            if (r_state == ST_EXEC) begin
                r_pc <= w_new_pc;
                if (r_delay_pending) begin
                    // transfers issued from a delay slot are ignored
                    r_delay_pending <= 1'b0;
                end else if (w_taken) begin
                    r_pending_target <= w_target;
                    r_delay_pending  <= 1'b1;
                end
                if (w_misaligned) r_fault <= 1'b1;
            end
        end
    end

    // Reset gates the read request directly so an in-flight read drops at once
    assign instr_address      = r_pc;
    assign instr_read         = reset && (r_state == ST_FETCH || r_state == ST_WAIT);
    assign instr_valid        = (r_state == ST_EXEC);
    assign instr_readdata_out = r_instr;
    assign pc_out             = r_pc;
    assign link_addr          = r_pc + 32'd8;
    assign active             = (r_state != ST_HALT);
    assign fault              = r_fault;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Bench for mips_cpu_fetch: acts as instruction memory and decoder, runs a
// table of single-transfer scenarios, hand-written corner sequences and a
// randomized run checked against a queue-based model of the delay slot rule.
module tb_mips_cpu_fetch;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic [31:0] instr_readdata_out;
    logic        instr_valid;
    logic [1:0]  pc_sel;
    logic        is_branch;
    logic        is_true;
    logic [31:0] reg_target;
    logic [31:0] pc_out;
    logic [31:0] link_addr;
    logic        active;
    logic        fault;

    mips_cpu_fetch dut (
        .clk                (clk),
        .reset              (reset),
        .clk_enable         (clk_enable),
        .instr_address      (instr_address),
        .instr_read         (instr_read),
        .instr_waitrequest  (instr_waitrequest),
        .instr_readdata     (instr_readdata),
        .instr_readdata_out (instr_readdata_out),
        .instr_valid        (instr_valid),
        .pc_sel             (pc_sel),
        .is_branch          (is_branch),
        .is_true            (is_true),
        .reg_target         (reg_target),
        .pc_out             (pc_out),
        .link_addr          (link_addr),
        .active             (active),
        .fault              (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem_ovr [logic [31:0]];

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  sel;
        logic        br;
        logic        tru;
        logic [31:0] rt;
        logic [31:0] exp3;  // pc of the instruction after the delay slot
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic dec_idle();
        pc_sel = 2'b00; is_branch = 1'b0; is_true = 1'b0; reg_target = 32'd0;
    endtask

    // Memory answers only when the read can actually complete this edge
    task automatic step(input bit wr, input bit en);
        instr_waitrequest = wr;
        clk_enable        = en;
        instr_readdata    = (wr || !en) ? 32'hDEAD_BEEF : mem_rd(instr_address);
    endtask

    // Idle the decoder until the next EXEC; n = clock edges taken
    task automatic wait_exec(input int budget, input int ws, input logic [31:0] exp_addr,
                             output int n);
        bit ok;
        int w;
        ok = 0; n = 0; w = ws;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (instr_valid) ok = 1;
            else begin
                if (instr_read) chk("fetch_addr", instr_address, exp_addr);
                dec_idle();
                if (instr_read && w > 0) begin step(1, 1); w--; end
                else step(0, 1);
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL exec_timeout: no instr_valid within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        dec_idle();
        mem_ovr.delete();
        instr_waitrequest = 1'b0;
        clk_enable        = 1'b1;
        instr_readdata    = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_read",   32'(instr_read),  32'd0);
        chk("rst_valid",  32'(instr_valid), 32'd0);
        chk("rst_active", 32'(active),      32'd1);
        chk("rst_fault",  32'(fault),       32'd0);
        chk("rst_instr",  instr_readdata_out, 32'd0);
        chk("rst_addr",   instr_address,    RV);
        chk("rst_link",   link_addr,        RV + 32'd8);
        reset = 1'b1;
        step(0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, reads, valids, instrs, cycles;
        logic [31:0] exp_pc, nxt, tgt, ins;
        logic [31:0] pend_q [$];
        bit en, wr, tk;

        vecs[0] = '{32'h1000_0003, 2'b01, 1'b1, 1'b1, 32'd0,        32'hBFC0_0010};
        vecs[1] = '{32'h1000_0003, 2'b01, 1'b1, 1'b0, 32'd0,        32'hBFC0_0008};
        vecs[2] = '{32'h0800_0100, 2'b10, 1'b1, 1'b0, 32'd0,        32'hB000_0400};
        vecs[3] = '{32'h0800_0100, 2'b10, 1'b0, 1'b1, 32'd0,        32'hBFC0_0008};
        vecs[4] = '{32'h0000_0008, 2'b11, 1'b1, 1'b0, 32'hBFC0_0200, 32'hBFC0_0200};
        vecs[5] = '{32'h1400_FFFE, 2'b01, 1'b1, 1'b1, 32'd0,        32'hBFBF_FFFC};
        vecs[6] = '{32'h2402_0005, 2'b00, 1'b1, 1'b1, 32'hBFC0_0300, 32'hBFC0_0008};

        reset = 1'b0;
        dec_idle();
        instr_waitrequest = 1'b0;
        clk_enable = 1'b1;
        instr_readdata = 32'd0;

        // Zero-wait fetch: first EXEC 2 edges after release, then every 3
        do_reset();
        mem_ovr[RV] = 32'h2402_0005;
        wait_exec(50, 0, RV, n);
        chk("lat_first", n, 2);
        chk("pc0", pc_out, RV);
        chk("instr0", instr_readdata_out, 32'h2402_0005);
        chk("active0", 32'(active), 32'd1);
        dec_idle();
        step(0, 1);
        wait_exec(50, 0, RV + 32'd4, n);
        chk("lat_next", n, 3);
        chk("pc1", pc_out, RV + 32'd4);

        // Four wait states on the first fetch delay EXEC by four cycles
        do_reset();
        wait_exec(50, 4, RV, n);
        chk("lat_ws4", n, 6);
        chk("pc_ws4", pc_out, RV);
        chk("instr_ws4", instr_readdata_out, mem_rd(RV));

        // Table: one transfer at RV; the delay slot tries JR, which must be ignored
        // when it is a real delay slot and only defers otherwise
        for (int i = 0; i < 7; i++) begin
            do_reset();
            mem_ovr[RV] = vecs[i].instr;
            wait_exec(50, 0, RV, n);
            chk($sformatf("v%0d_link", i), link_addr, RV + 32'd8);
            pc_sel = vecs[i].sel; is_branch = vecs[i].br;
            is_true = vecs[i].tru; reg_target = vecs[i].rt;
            step(0, 1);
            wait_exec(50, 0, RV + 32'd4, n);
            chk($sformatf("v%0d_slot", i), pc_out, RV + 32'd4);
            pc_sel = 2'b11; is_branch = 1'b1; is_true = 1'b0; reg_target = 32'hBFC0_0800;
            step(0, 1);
            wait_exec(50, 0, vecs[i].exp3, n);
            chk($sformatf("v%0d_target", i), pc_out, vecs[i].exp3);
        end

        // JR to 0: delay slot runs, then halt with no further fetches
        for (int k = 0; k < 2; k++) begin
            do_reset();
            wait_exec(50, 0, RV, n);
            pc_sel = 2'b11; is_branch = 1'b1; is_true = 1'b0;
            reg_target = (k == 0) ? 32'd0 : 32'hBFC0_0102;
            step(0, 1);
            wait_exec(50, 0, RV + 32'd4, n);
            chk("halt_slot_pc", pc_out, RV + 32'd4);
            dec_idle();
            step(0, 1);
            reads = 0; valids = 0;
            repeat (12) begin
                @(negedge clk);
                reads += int'(instr_read);
                valids += int'(instr_valid);
                step(0, 1);
            end
            chk($sformatf("halt%0d_reads", k),  reads, 0);
            chk($sformatf("halt%0d_valids", k), valids, 0);
            chk($sformatf("halt%0d_active", k), 32'(active), 32'd0);
            chk($sformatf("halt%0d_fault", k),  32'(fault), (k == 0) ? 32'd0 : 32'd1);
        end

        // Reset asserted during WAIT drops the read immediately and restarts at RV
        do_reset();
        wait_exec(50, 0, RV, n);
        dec_idle();
        step(0, 1);
        @(negedge clk);
        step(1, 1);
        @(negedge clk);
        chk("rw_read_before", 32'(instr_read), 32'd1);
        chk("rw_addr_before", instr_address, RV + 32'd4);
        step(1, 1);
        reset = 1'b0;
        #1;
        chk("rw_read_drop", 32'(instr_read), 32'd0);
        @(negedge clk);
        chk("rw_addr_reset", instr_address, RV);
        reset = 1'b1;
        step(0, 1);
        wait_exec(50, 0, RV, n);
        chk("rw_lat", n, 2);
        chk("rw_pc", pc_out, RV);

        // Randomized run: random stalls, freezes and decoder outputs
        do_reset();
        exp_pc = RV;
        pend_q.delete();
        instrs = 0; cycles = 0;
        while (instrs < 300 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            chk("rnd_addr", instr_address, exp_pc);
            en = ($urandom_range(0, 4) != 0);
            wr = instr_read && ($urandom_range(0, 3) == 0);
            dec_idle();
            if (instr_valid) begin
                chk("rnd_pc", pc_out, exp_pc);
                chk("rnd_instr", instr_readdata_out, mem_rd(exp_pc));
                chk("rnd_link", link_addr, exp_pc + 32'd8);
                pc_sel     = 2'($urandom_range(0, 3));
                is_branch  = 1'($urandom_range(0, 1));
                is_true    = 1'($urandom_range(0, 1));
                reg_target = {16'hBFC0, 16'($urandom) & 16'hFFFC};
                if (en) begin
                    ins = mem_rd(exp_pc);
                    tk  = is_branch && (pc_sel == 2'b10 || pc_sel == 2'b11 ||
                                        (pc_sel == 2'b01 && is_true));
                    if (pc_sel == 2'b01)
                        tgt = exp_pc + 32'd4 + 32'($signed(ins[15:0])) * 32'd4;
                    else if (pc_sel == 2'b10)
                        tgt = {exp_pc[31:28] + ((exp_pc[27:0] >= 28'hFFFFFFC) ? 4'd1 : 4'd0),
                               ins[25:0], 2'b00};
                    else
                        tgt = reg_target;
                    if (pend_q.size() != 0) nxt = pend_q.pop_front();
                    else begin
                        if (tk) pend_q.push_back(tgt);
                        nxt = exp_pc + 32'd4;
                    end
                    exp_pc = nxt;
                    instrs++;
                end
            end
            step(wr, en);
        end
        chk("rnd_instrs", instrs, 300);
        chk("rnd_active", 32'(active), 32'd1);
        chk("rnd_fault", 32'(fault), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
